call_scheduler: RTL and testbench

CALL_SCHEDULER -- requirements
Module: call_scheduler

---
 rtl/call_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_call_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/call_scheduler.sv
// call_scheduler: three-floor elevator call scheduler (IDLE/UP/DOWN/SERVE/HALT).
// Optional home-return feature: define CALL_SCHEDULER_HOME_EN to enable the idle
// counter that recalls an unused car to floor 2'b00 after HOME_TIMEOUT cycles.
module call_scheduler #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned HOME_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] call,
  input  logic [1:0] cur_floor,
  input  logic       moving,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  output logic [2:0] pending,
  output logic [1:0] goal_floor,
  output logic       goal_valid,
  output logic       dir_up,
  output logic       serve_done
);

  localparam int unsigned FLR_W   = 2;
  localparam int unsigned NFLOOR  = 3;
  // One width serves both the dwell and the idle counters.
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > HOME_TIMEOUT) ? DWELL_CYCLES : HOME_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_SERVE = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [NFLOOR-1:0]   pending_q, pending_d;
  logic [FLR_W-1:0]    goal_q, goal_d;
  logic                goal_valid_q, goal_valid_d;
  logic                dir_up_q, dir_up_d;
  logic                serve_done_q, serve_done_d;
  logic [CNT_W-1:0]    dwell_q, dwell_d;
`ifdef CALL_SCHEDULER_HOME_EN
  logic [CNT_W-1:0]    idle_q, idle_d;
`endif

  logic                floor_ok_c;
  logic [NFLOOR-1:0]   cur_bit_c, above_c, below_c, ge_c, le_c;
  logic                at_cur_c, any_above_c, any_below_c;
  logic                up_found_c, dn_found_c;
  logic [FLR_W-1:0]    up_goal_c, dn_goal_c;
  logic                enter_serve_c;

  // Decode car position and the nearest pending floor in each direction
  always_comb begin
    floor_ok_c = (cur_floor != 2'b11);
    cur_bit_c  = 3'b000;
    above_c    = 3'b000;
    below_c    = 3'b000;
    case (cur_floor)
      2'b00:   begin cur_bit_c = 3'b001; above_c = 3'b110; end
      2'b01:   begin cur_bit_c = 3'b010; above_c = 3'b100; below_c = 3'b001; end
      2'b10:   begin cur_bit_c = 3'b100; below_c = 3'b011; end
      default: ;
    endcase
    at_cur_c    = |(pending_q & cur_bit_c);
    any_above_c = |(pending_q & above_c);
    any_below_c = |(pending_q & below_c);
    // Include the current floor so a goal reached at a stop is still seen.
    ge_c        = pending_q & (above_c | cur_bit_c);
    le_c        = pending_q & (below_c | cur_bit_c);
    up_found_c  = |ge_c;
    dn_found_c  = |le_c;
    up_goal_c   = ge_c[0] ? 2'b00 : (ge_c[1] ? 2'b01 : 2'b10);
    dn_goal_c   = le_c[2] ? 2'b10 : (le_c[1] ? 2'b01 : 2'b00);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: sos wins, then HALT exit, then invalid-floor hold
  always_comb begin
    state_d = state_q;
    if (sos_mode) begin
      state_d = S_HALT;
    end else if (state_q == S_HALT) begin
      state_d = S_IDLE;
    end else if (floor_ok_c) begin
      case (state_q)
        S_IDLE: begin
          if (at_cur_c && !moving) begin
            state_d = S_SERVE;
          end else if (!weight_limit_exceeded) begin
            if (any_above_c && !any_below_c)      state_d = S_UP;
            else if (any_below_c && !any_above_c) state_d = S_DOWN;
            else if (any_above_c && any_below_c)  state_d = dir_up_q ? S_UP : S_DOWN;
          end
        end
        S_UP: begin
          if (!up_found_c)                                state_d = S_IDLE;
          else if ((cur_floor == up_goal_c) && !moving)   state_d = S_SERVE;
        end
        S_DOWN: begin
          if (!dn_found_c)                                state_d = S_IDLE;
          else if ((cur_floor == dn_goal_c) && !moving)   state_d = S_SERVE;
        end
        S_SERVE: begin
          if (!weight_limit_exceeded && (dwell_q == '0)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values, all registered below
  always_comb begin
    enter_serve_c = (state_d == S_SERVE) && (state_q != S_SERVE);

    pending_d = pending_q;
    if (state_q != S_HALT) pending_d = pending_d | call;

`ifdef CALL_SCHEDULER_HOME_EN
    idle_d = '0;
    if ((state_q == S_IDLE) && (state_d == S_IDLE) && (call == 3'b000) &&
        (pending_q == 3'b000) && floor_ok_c && (cur_floor != 2'b00)) begin
      if (idle_q == CNT_W'(HOME_TIMEOUT - 1)) pending_d = pending_d | 3'b001;
      else                                    idle_d    = idle_q + CNT_W'(1);
    end
`endif

    // Arrival clear wins over a same-cycle call for this floor.
    if (enter_serve_c) pending_d = pending_d & ~cur_bit_c;

    dwell_d = dwell_q;
    if (state_d != S_SERVE)
      dwell_d = '0;
    else if (state_q != S_SERVE)
      dwell_d = CNT_W'(DWELL_CYCLES - 1);
    else if (floor_ok_c && !weight_limit_exceeded && (dwell_q != '0))
      dwell_d = dwell_q - CNT_W'(1);

    goal_valid_d = floor_ok_c && ((state_d == S_UP) || (state_d == S_DOWN));

    goal_d = goal_q;
    if (floor_ok_c) begin
      if (state_d == S_UP)        goal_d = up_goal_c;
      else if (state_d == S_DOWN) goal_d = dn_goal_c;
      else                        goal_d = cur_floor;
    end

    dir_up_d = dir_up_q;
    if (state_d == S_UP)        dir_up_d = 1'b1;
    else if (state_d == S_DOWN) dir_up_d = 1'b0;

    serve_done_d = (state_q == S_SERVE) && (state_d == S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      goal_q       <= '0;
      goal_valid_q <= 1'b0;
      dir_up_q     <= 1'b1;
      serve_done_q <= 1'b0;
      dwell_q      <= '0;
`ifdef CALL_SCHEDULER_HOME_EN
      idle_q       <= '0;
`endif
    end else begin
      pending_q    <= pending_d;
      goal_q       <= goal_d;
      goal_valid_q <= goal_valid_d;
      dir_up_q     <= dir_up_d;
      serve_done_q <= serve_done_d;
      dwell_q      <= dwell_d;
`ifdef CALL_SCHEDULER_HOME_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign pending    = pending_q;
  assign goal_floor = goal_q;
  assign goal_valid = goal_valid_q;
  assign dir_up     = dir_up_q;
  assign serve_done = serve_done_q;

endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: directed self-checking bench for call_scheduler.
module tb_call_scheduler;

  logic       clk;
  logic       reset_n;
  logic [2:0] call;
  logic [1:0] cur_floor;
  logic       moving;
  logic       sos_mode;
  logic       weight;
  logic [2:0] pending;
  logic [1:0] goal_floor;
  logic       goal_valid;
  logic       dir_up;
  logic       serve_done;

  int n_checks;
  int n_pass;
  int lat;

  call_scheduler #(
    .DWELL_CYCLES(4),
    .HOME_TIMEOUT(16)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .call                 (call),
    .cur_floor            (cur_floor),
    .moving               (moving),
    .sos_mode             (sos_mode),
    .weight_limit_exceeded(weight),
    .pending              (pending),
    .goal_floor           (goal_floor),
    .goal_valid           (goal_valid),
    .dir_up               (dir_up),
    .serve_done           (serve_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for serve_done; returns edges taken, 0 if it never came.
  task automatic wait_done(output int l);
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (serve_done === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    call     = 3'b000;
    cur_floor = 2'b00;
    moving   = 1'b0;
    sos_mode = 1'b0;
    weight   = 1'b0;
    tick();
    tick();
    check("rst_pending", 32'(pending), 'h0);
    check("rst_goal", 32'(goal_floor), 'h0);
    check("rst_valid", 32'(goal_valid), 'h0);
    check("rst_dir_up", 32'(dir_up), 'h1);
    check("rst_done", 32'(serve_done), 'h0);
    reset_n = 1'b1;
    tick();

    // Call to top floor from idle at floor 0
    call = 3'b100;
    tick();
    check("lat_pending", 32'(pending), 'h4);
    check("lat_valid_early", 32'(goal_valid), 'h0);
    call = 3'b000;
    tick();
    check("lat_goal", 32'(goal_floor), 'h2);
    check("lat_valid", 32'(goal_valid), 'h1);
    check("lat_dir", 32'(dir_up), 'h1);

    // Intermediate call while travelling up replaces the goal
    moving = 1'b1;
    call   = 3'b010;
    tick();
    check("mid_pending", 32'(pending), 'h6);
    call = 3'b000;
    tick();
    check("mid_goal", 32'(goal_floor), 'h1);
    check("mid_valid", 32'(goal_valid), 'h1);
    cur_floor = 2'b01;
    moving    = 1'b0;
    tick();
    check("mid_serve_pending", 32'(pending), 'h4);
    check("mid_serve_valid", 32'(goal_valid), 'h0);
    wait_done(lat);
    check("mid_dwell", 32'(lat), 'h4);
    tick();
    check("resume_goal", 32'(goal_floor), 'h2);
    check("resume_valid", 32'(goal_valid), 'h1);
    check("resume_done_low", 32'(serve_done), 'h0);
    cur_floor = 2'b10;
    tick();
    check("top_pending", 32'(pending), 'h0);
    wait_done(lat);
    check("top_dwell", 32'(lat), 'h4);

    // Dwell with overload frozen for 3 cycles
    call = 3'b100;
    tick();
    call = 3'b000;
    tick();
    check("ovl_serve_pending", 32'(pending), 'h0);
    weight = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) weight = 1'b0;
      if (serve_done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("ovl_dwell", 32'(lat), 'h7);

    // Get dir_up=0, then park at floor 1 with both directions pending
    call = 3'b001;
    tick();
    call = 3'b000;
    tick();
    check("down_dir", 32'(dir_up), 'h0);
    check("down_goal", 32'(goal_floor), 'h0);
    cur_floor = 2'b01;
    moving    = 1'b1;
    sos_mode  = 1'b1;
    tick();
    check("halt_valid", 32'(goal_valid), 'h0);
    check("halt_pending", 32'(pending), 'h1);
    sos_mode = 1'b0;
    weight   = 1'b1;
    moving   = 1'b0;
    tick();
    call = 3'b100;
    tick();
    check("both_pending", 32'(pending), 'h5);
    call = 3'b000;
    tick();
    check("ovl_block", 32'(goal_valid), 'h0);
    weight = 1'b0;
    tick();
    check("both_valid", 32'(goal_valid), 'h1);
    check("both_goal", 32'(goal_floor), 'h0);
    check("both_dir", 32'(dir_up), 'h0);
    cur_floor = 2'b00;
    tick();
    check("f0_pending", 32'(pending), 'h4);
    wait_done(lat);
    check("f0_dwell", 32'(lat), 'h4);
    tick();
    check("up_again_dir", 32'(dir_up), 'h1);
    check("up_again_goal", 32'(goal_floor), 'h2);

    // SOS during UP: goal dropped, pending kept, calls ignored in HALT
    sos_mode = 1'b1;
    tick();
    check("sos_valid", 32'(goal_valid), 'h0);
    check("sos_pending", 32'(pending), 'h4);
    sos_mode = 1'b0;
    call     = 3'b010;
    tick();
    check("sos_call_ignored", 32'(pending), 'h4);
    call = 3'b000;
    tick();
    check("sos_resume_valid", 32'(goal_valid), 'h1);
    check("sos_resume_goal", 32'(goal_floor), 'h2);

    // Invalid floor code holds state and drops goal_valid for that cycle
    cur_floor = 2'b11;
    tick();
    check("bad_floor_valid", 32'(goal_valid), 'h0);
    check("bad_floor_goal", 32'(goal_floor), 'h2);
    cur_floor = 2'b00;
    tick();
    check("good_floor_valid", 32'(goal_valid), 'h1);

    // Asynchronous reset mid-travel, no clock edge needed
    reset_n = 1'b0;
    #2;
    check("async_pending", 32'(pending), 'h0);
    check("async_valid", 32'(goal_valid), 'h0);
    check("async_goal", 32'(goal_floor), 'h0);
    cur_floor = 2'b10;
    tick();
    reset_n = 1'b1;

    // Idle at floor 2 with no calls
`ifdef CALL_SCHEDULER_HOME_EN
    repeat (15) tick();
    check("home_early", 32'(pending), 'h0);
    tick();
    check("home_set", 32'(pending), 'h1);
    tick();
    check("home_goal", 32'(goal_floor), 'h0);
    check("home_valid", 32'(goal_valid), 'h1);
`else
    repeat (40) tick();
    check("no_home_pending", 32'(pending), 'h0);
    check("no_home_valid", 32'(goal_valid), 'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
